// File: rtl/chess_ctrl_pkg.sv
// Shared types and constants for the move-list writer.
package chess_ctrl_pkg;

  // Drain engine states
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_KICK,
    ST_WAIT,
    ST_REQ,
    ST_LATCH,
    ST_SCAN,
    ST_HDR,
    ST_TERM,
    ST_DONE
  } lw_state_e;

  // Slot flag value that marks an empty/invalid slot
  localparam logic SLOT_INVALID = 1'b1;

  // Offsets from the list base: count header, then the first move.
  // The terminator sits at MOVE_OFFSET + count.
  localparam int HDR_OFFSET  = 0;
  localparam int MOVE_OFFSET = 1;

endpackage

// File: rtl/lmg_list_writer_slot_select.sv
// Combinational slot extract: picks one packed slot of a FIFO word by index.
module lmg_slot_select
  import chess_ctrl_pkg::*;
#(
  parameter int SLOTS  = 8,
  parameter int MOVE_W = 18,
  parameter int IDX_W  = 3
) (
  input  logic [SLOTS*(MOVE_W+1)-1:0] word,
  input  logic [IDX_W-1:0]            idx,
  output logic [MOVE_W-1:0]           payload,
  output logic                        invalid
);

  localparam int SLOT_W = MOVE_W + 1;

  logic [SLOTS-1:0][SLOT_W-1:0] slotArr;
  logic [SLOT_W-1:0]            sel;

  assign slotArr = word;

  // index mux; out-of-range index reads as an all-zero slot
  always_comb begin
    sel = '0;
    for (int i = 0; i < SLOTS; i++)
      if (idx == IDX_W'(i)) sel = slotArr[i];
  end

  assign payload = sel[MOVE_W-1:0];
  assign invalid = (sel[MOVE_W] == SLOT_INVALID);

endmodule

// File: rtl/lmg_list_writer.sv
// Drains LMG FIFO words into a compacted move list in RAM:
// moves at LIST_BASE+1.., count header at LIST_BASE, zero terminator after.
module lmg_list_writer
  import chess_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 15,
  parameter int SLOTS      = 8,
  parameter int MOVE_W     = 18,
  parameter int LIST_BASE  = 16,
  parameter int MAX_MOVES  = 255
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             start,
  output logic                             done,
  output logic                             overflow,
  output logic [$clog2(MAX_MOVES+1)-1:0]   move_count,
  output logic                             lmg_reset,
  input  logic                             lmg_done,
  input  logic                             lmg_fifo_empty,
  output logic                             lmg_rden,
  input  logic [SLOTS*(MOVE_W+1)-1:0]      lmg_fifo_out,
  output logic                             ram_wren,
  output logic [ADDR_WIDTH-1:0]            ram_wraddr,
  output logic [DATA_WIDTH-1:0]            ram_data
);

  localparam int CNT_W  = $clog2(MAX_MOVES+1);
  localparam int IDX_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int WORD_W = SLOTS * (MOVE_W + 1);

  localparam logic [ADDR_WIDTH-1:0] HDR_ADDR  = ADDR_WIDTH'(LIST_BASE + HDR_OFFSET);
  localparam logic [ADDR_WIDTH-1:0] MOVE_ADDR = ADDR_WIDTH'(LIST_BASE + MOVE_OFFSET);
  localparam logic [CNT_W-1:0]      CNT_MAX   = CNT_W'(MAX_MOVES);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(SLOTS - 1);

  lw_state_e state, nxtState;

  logic [WORD_W-1:0] wordReg;
  logic [IDX_W-1:0]  slotIdx;
  logic              anyValid;

  logic [MOVE_W-1:0] slotPayload;
  logic              slotInvalid;

  logic                  nxtReset, nxtRden, nxtWren, nxtDone;
  logic [ADDR_WIDTH-1:0] nxtAddr, termAddr;
  logic [DATA_WIDTH-1:0] nxtData;
  logic                  clrRun, incCount, setOvf, abort;

  lmg_slot_select #(
    .SLOTS  (SLOTS),
    .MOVE_W (MOVE_W),
    .IDX_W  (IDX_W)
  ) uSel (
    .word    (wordReg),
    .idx     (slotIdx),
    .payload (slotPayload),
    .invalid (slotInvalid)
  );

  // count never exceeds MAX_MOVES, the clamp just keeps the bound explicit
  assign termAddr = (move_count >= CNT_MAX) ? MOVE_ADDR + ADDR_WIDTH'(CNT_MAX)
                                            : MOVE_ADDR + ADDR_WIDTH'(move_count);

  assign abort = !start && (state != ST_IDLE) && (state != ST_DONE);

  // next state plus the values the output registers take on this edge;
  // outputs are derived from the next state so they line up with it
  always_comb begin
    nxtState = state;
    nxtReset = 1'b0;
    nxtRden  = 1'b0;
    nxtWren  = 1'b0;
    nxtAddr  = ram_wraddr;
    nxtData  = ram_data;
    nxtDone  = 1'b0;
    clrRun   = 1'b0;
    incCount = 1'b0;
    setOvf   = 1'b0;

    case (state)
      ST_IDLE:  if (start) nxtState = ST_KICK;
      ST_KICK:  nxtState = ST_WAIT;
      ST_WAIT:  if (lmg_done) nxtState = ST_REQ;
      ST_REQ:   nxtState = lmg_fifo_empty ? ST_HDR : ST_LATCH;
      ST_LATCH: nxtState = ST_SCAN;
      ST_SCAN: begin
        if (!slotInvalid) begin
          if (move_count < CNT_MAX) begin
            nxtWren  = 1'b1;
            nxtAddr  = MOVE_ADDR + ADDR_WIDTH'(move_count);
            nxtData  = DATA_WIDTH'(slotPayload);
            incCount = 1'b1;
          end else begin
            setOvf = 1'b1;
          end
        end
        // an all-invalid word marks the end of the list
        if (slotIdx == IDX_LAST)
          nxtState = (anyValid || !slotInvalid) ? ST_REQ : ST_HDR;
      end
      ST_HDR:   nxtState = ST_TERM;
      ST_TERM:  nxtState = ST_DONE;
      ST_DONE:  if (!start) nxtState = ST_IDLE;
      default:  nxtState = ST_IDLE;
    endcase

    if (abort) begin
      nxtState = ST_IDLE;
      nxtWren  = 1'b0;
      incCount = 1'b0;
      setOvf   = 1'b0;
    end

    clrRun   = (state == ST_IDLE) && start;
    nxtReset = (state == ST_IDLE) && (nxtState == ST_KICK);
    nxtRden  = (state == ST_REQ) && (nxtState == ST_LATCH);
    nxtDone  = (nxtState == ST_DONE);

    if (nxtState == ST_HDR) begin
      nxtWren = 1'b1;
      nxtAddr = HDR_ADDR;
      nxtData = DATA_WIDTH'(move_count);
    end else if (nxtState == ST_TERM) begin
      nxtWren = 1'b1;
      nxtAddr = termAddr;
      nxtData = '0;
    end
  end

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= nxtState;
  end

  // registered outputs, move count and sticky overflow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lmg_reset  <= 1'b0;
      lmg_rden   <= 1'b0;
      ram_wren   <= 1'b0;
      ram_wraddr <= '0;
      ram_data   <= '0;
      done       <= 1'b0;
      move_count <= '0;
      overflow   <= 1'b0;
    end else begin
      lmg_reset  <= nxtReset;
      lmg_rden   <= nxtRden;
      ram_wren   <= nxtWren;
      ram_wraddr <= nxtAddr;
      ram_data   <= nxtData;
      done       <= nxtDone;
      if (clrRun) begin
        move_count <= '0;
        overflow   <= 1'b0;
      end else begin
        if (incCount) move_count <= move_count + CNT_W'(1);
        if (setOvf)   overflow   <= 1'b1;
      end
    end
  end

  // FIFO word capture and slot walk
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wordReg  <= '0;
      slotIdx  <= '0;
      anyValid <= 1'b0;
    end else if (state == ST_LATCH) begin
      wordReg  <= lmg_fifo_out;
      slotIdx  <= '0;
      anyValid <= 1'b0;
    end else if (state == ST_SCAN) begin
      slotIdx  <= slotIdx + IDX_W'(1);
      anyValid <= anyValid | !slotInvalid;
    end
  end

endmodule

// File: tb/tb_lmg_list_writer.sv
// Randomized bench for lmg_list_writer with a list-level reference model.
module tb_lmg_list_writer;

  localparam int DW   = 32;
  localparam int AW   = 15;
  localparam int SL   = 8;
  localparam int MW   = 18;
  localparam int BASE = 16;
  localparam int MAXM = 12;
  localparam int SW   = SL * (MW + 1);
  localparam int CW   = $clog2(MAXM + 1);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          lmg_done = 1'b0;
  logic          done, overflow, lmg_reset, lmg_rden, lmg_fifo_empty, ram_wren;
  logic [CW-1:0] move_count;
  logic [SW-1:0] lmg_fifo_out;
  logic [AW-1:0] ram_wraddr;
  logic [DW-1:0] ram_data;

  always #5 clk = ~clk;

  lmg_list_writer #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .SLOTS (SL),
    .MOVE_W (MW), .LIST_BASE (BASE), .MAX_MOVES (MAXM)
  ) dut (
    .clk (clk), .reset_n (reset_n), .start (start), .done (done),
    .overflow (overflow), .move_count (move_count), .lmg_reset (lmg_reset),
    .lmg_done (lmg_done), .lmg_fifo_empty (lmg_fifo_empty), .lmg_rden (lmg_rden),
    .lmg_fifo_out (lmg_fifo_out), .ram_wren (ram_wren), .ram_wraddr (ram_wraddr),
    .ram_data (ram_data)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // show-ahead FIFO: head is stimArr[popTotal-popBase], popped on rden
  logic [SW-1:0] stimArr [0:15];
  int nWords = 0;
  int popTotal = 0;
  int popBase = 0;
  int headIdx;
  assign headIdx        = popTotal - popBase;
  assign lmg_fifo_empty = !(headIdx < nWords);
  assign lmg_fifo_out   = lmg_fifo_empty ? '0 : stimArr[headIdx];

  always @(posedge clk) if (reset_n && lmg_rden) popTotal++;

  // RAM / port monitor (append-only logs, read by the main thread)
  logic [DW-1:0] ram [0:63];
  logic [AW-1:0] wAddr[$];
  logic [DW-1:0] wData[$];
  int popCyc[$];
  int cyc = 0, badAddr = 0, rdB2B = 0, rstB2B = 0, emptyPop = 0;
  bit prevRd = 0, prevRst = 0;

  always @(negedge clk) begin
    cyc++;
    if (reset_n) begin
      if (ram_wren) begin
        wAddr.push_back(ram_wraddr);
        wData.push_back(ram_data);
        ram[ram_wraddr[5:0]] = ram_data;
        if (ram_wraddr > AW'(BASE + 1 + MAXM)) badAddr++;
      end
      if (lmg_rden) begin
        if (prevRd) rdB2B++;
        if (lmg_fifo_empty) emptyPop++;
        popCyc.push_back(cyc);
      end
      if (lmg_reset && prevRst) rstB2B++;
      prevRd  = lmg_rden;
      prevRst = lmg_reset;
    end
  end

  // reference model: walk the words as software would read the list
  int expA[$];
  int expD[$];
  int expCnt, expPops;
  bit expOvf, expEmptyEnd;

  task automatic buildExp();
    logic [SW-1:0] w;
    logic [MW:0]   s;
    bit any;
    expA.delete(); expD.delete();
    expCnt = 0; expOvf = 0; expPops = 0; expEmptyEnd = 1;
    for (int wi = 0; wi < nWords; wi++) begin
      w = stimArr[wi];
      expPops++;
      any = 0;
      for (int k = 0; k < SL; k++) begin
        s = w[k*(MW+1) +: MW+1];
        if (!s[MW]) begin
          any = 1;
          if (expCnt < MAXM) begin
            expA.push_back(BASE + 1 + expCnt);
            expD.push_back(int'(s[MW-1:0]));
            expCnt++;
          end else expOvf = 1;
        end
      end
      if (!any) begin expEmptyEnd = 0; break; end
    end
    expA.push_back(BASE);              expD.push_back(expCnt);
    expA.push_back(BASE + 1 + expCnt); expD.push_back(0);
  endtask

  function automatic logic [SW-1:0] randWord(input int dens);
    logic [SW-1:0] w;
    w = '0;
    for (int k = 0; k < SL; k++)
      w[k*(MW+1) +: MW+1] = {($urandom_range(0, 3) >= dens), MW'($urandom)};
    return w;
  endfunction

  task automatic waitKick(input string nm);
    bit seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); seen = lmg_reset; end
    chk({nm, "_kick"}, seen, 1);
    popBase = popTotal;
  endtask

  task automatic waitRden(input string nm);
    bit seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk); seen = lmg_rden; end
    chk({nm, "_rden"}, seen, 1);
  endtask

  // one complete run of the list against the model
  task automatic runList(input string nm, input int waitCyc);
    int n, w0, p0, nw;
    bit seen;
    buildExp();
    w0 = wAddr.size(); p0 = popCyc.size();
    start = 1;
    waitKick(nm);
    chk({nm, "_cnt0"}, move_count, 0);
    chk({nm, "_ovf0"}, overflow, 0);
    repeat (waitCyc) @(negedge clk);
    lmg_done = 1; n = 0; seen = 0;
    while (!seen && n < 3000) begin @(negedge clk); n++; seen = done; end
    chk({nm, "_done"}, seen, 1);
    chk({nm, "_lat"}, n, expPops * (SL + 2) + (expEmptyEnd ? 4 : 3));
    nw = wAddr.size() - w0;
    chk({nm, "_nwr"}, nw, expA.size());
    for (int i = 0; i < nw && i < expA.size(); i++) begin
      chk({nm, "_waddr"}, wAddr[w0+i], expA[i]);
      chk({nm, "_wdata"}, wData[w0+i], expD[i]);
    end
    chk({nm, "_ovf"}, overflow, expOvf);
    chk({nm, "_cnt"}, move_count, expCnt);
    chk({nm, "_pops"}, popTotal - popBase, expPops);
    for (int i = p0 + 1; i < popCyc.size(); i++)
      chk({nm, "_popgap"}, popCyc[i] - popCyc[i-1], SL + 2);
    start = 0; lmg_done = 0;
    @(negedge clk); @(negedge clk);
    chk({nm, "_donelow"}, done, 0);
  endtask

  function automatic logic [SW-1:0] basicWord();
    logic [SW-1:0] w;
    w = '1;
    w[0*(MW+1) +: MW+1] = {1'b0, 18'h00101};
    w[2*(MW+1) +: MW+1] = {1'b0, 18'h00202};
    w[5*(MW+1) +: MW+1] = {1'b0, 18'h00505};
    return w;
  endfunction

  initial begin
    int w0, p0, bad0;

    #2;
    chk("rst_done", done, 0);
    chk("rst_outs", {overflow, move_count, lmg_reset, lmg_rden, ram_wren, ram_wraddr, ram_data}, 0);
    @(negedge clk); reset_n = 1; @(negedge clk);

    // three valid slots then an all-invalid word
    stimArr[0] = basicWord(); stimArr[1] = '1; nWords = 2;
    runList("basic", 2);
    chk("basic_r17", ram[17], 32'h101);
    chk("basic_r18", ram[18], 32'h202);
    chk("basic_r19", ram[19], 32'h505);
    chk("basic_r16", ram[16], 3);
    chk("basic_r20", ram[20], 0);

    // FIFO already empty when LMG reports done
    nWords = 0;
    runList("empty", 1);
    chk("empty_r16", ram[16], 0);
    chk("empty_r17", ram[17], 0);

    // more valid moves than capacity
    bad0 = badAddr;
    stimArr[0] = randWord(4); stimArr[1] = randWord(4); stimArr[2] = '1; nWords = 3;
    runList("ovf", 3);
    chk("ovf_r16", ram[16], MAXM);
    chk("ovf_term", ram[BASE + 1 + MAXM], 0);
    chk("ovf_hiaddr", badAddr - bad0, 0);
    chk("ovf_sticky", overflow, 1);

    // abort during the scan of the first word
    stimArr[0] = basicWord(); stimArr[1] = basicWord(); nWords = 2;
    start = 1;
    waitKick("abort");
    @(negedge clk); lmg_done = 1;
    waitRden("abort");
    @(negedge clk); @(negedge clk);
    start = 0; lmg_done = 0;
    @(posedge clk); #1;
    w0 = wAddr.size(); p0 = popCyc.size();
    repeat (20) @(negedge clk);
    chk("abort_nowr", wAddr.size() - w0, 0);
    chk("abort_nopop", popCyc.size() - p0, 0);
    chk("abort_done", done, 0);
    chk("abort_hold", move_count, 1);
    runList("rearm", 2);

    // asynchronous reset in the middle of a scan
    stimArr[0] = randWord(4); stimArr[1] = '1; nWords = 2;
    start = 1;
    waitKick("areset");
    @(negedge clk); lmg_done = 1;
    waitRden("areset");
    @(negedge clk); @(negedge clk);
    #1 reset_n = 0;
    #1;
    chk("areset_done", done, 0);
    chk("areset_outs", {overflow, move_count, lmg_reset, lmg_rden, ram_wren, ram_wraddr, ram_data}, 0);
    start = 0; lmg_done = 0;
    @(negedge clk); reset_n = 1; @(negedge clk);
    runList("postrst", 1);

    // randomized lists
    for (int r = 0; r < 25; r++) begin
      int dens;
      dens = $urandom_range(0, 4);
      nWords = $urandom_range(0, 5);
      for (int i = 0; i < nWords; i++) stimArr[i] = randWord(dens);
      if (nWords > 0 && $urandom_range(0, 1)) stimArr[$urandom_range(0, nWords - 1)] = '1;
      runList("rand", $urandom_range(1, 4));
    end

    chk("rden_b2b", rdB2B, 0);
    chk("kick_width", rstB2B, 0);
    chk("pop_empty", emptyPop, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
